c499_key_loader: RTL and testbench

C499_KEY_LOADER -- requirements
Module: c499_key_loader

---
 rtl/c499_key_pkg.sv | 27 ++
 rtl/c499_key_chk.sv | 27 ++
 rtl/c499_key_loader.sv | 135 +++++++++++++
 tb/tb_c499_key_loader.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/c499_key_pkg.sv
`default_nettype none
// ============================================================================
// Module  : c499_key_pkg
// Brief   : Shared widths and state encoding for the c499 key loader.
// Rev     : 1.0 - initial release
// ============================================================================
package c499_key_pkg;

    localparam int KEY_W_DEF   = 32;
    localparam int CHK_W_DEF   = 8;
    localparam int FRAME_W_DEF = KEY_W_DEF + CHK_W_DEF;
    localparam int CNT_W_DEF   = $clog2(FRAME_W_DEF + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_LOCKED = 2'd2,
        ST_ERROR  = 2'd3
    } state_e;

    // Counter must be able to hold the value FRAME_W itself, not just FRAME_W-1
    function automatic int cnt_width(input int frame_w);
        return $clog2(frame_w + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/c499_key_chk.sv
`default_nettype none
// ============================================================================
// Module  : c499_key_chk
// Brief   : Combinational XOR fold of all CHK_W-bit slices of the key.
// Rev     : 1.0 - initial release
// ============================================================================
module c499_key_chk
    import c499_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic [KEY_W-1:0] i_key,
    output logic [CHK_W-1:0] o_chk
);

    localparam int c_NSLICE = KEY_W / CHK_W;

    always_comb begin
        o_chk = '0;
        for (int i = 0; i < c_NSLICE; i++) begin
            o_chk = o_chk ^ i_key[i*CHK_W +: CHK_W];
        end
    end

endmodule
`default_nettype wire

// File: rtl/c499_key_loader.sv
`default_nettype none
// ============================================================================
// Module  : c499_key_loader
// Brief   : Serial, checksum-verified key loader for the locked c499 decoder.
// Rev     : 1.0 - initial release
// ============================================================================
module c499_key_loader
    import c499_key_pkg::*;
#(
    parameter int KEY_W = KEY_W_DEF,
    parameter int CHK_W = CHK_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             key_sdi,
    input  logic             key_sen,
    input  logic             key_commit,
    input  logic             key_clear,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_err,
    output logic             busy
);

    localparam int                 c_FRAME_W  = KEY_W + CHK_W;
    localparam int                 c_CNT_W    = cnt_width(c_FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_W);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    state_e               r_state;
    state_e               w_state_nxt;
    logic [c_FRAME_W-1:0] r_sr;
    logic [c_FRAME_W-1:0] w_sr_nxt;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_CNT_W-1:0]   w_cnt_nxt;
    logic [KEY_W-1:0]     r_key;
    logic [KEY_W-1:0]     w_key_nxt;
    logic                 r_valid;
    logic                 r_err;
    logic                 r_busy;
    logic                 w_valid_nxt;
    logic                 w_err_nxt;
    logic                 w_busy_nxt;
    logic [CHK_W-1:0]     w_chk_calc;
    logic                 w_full;
    logic                 w_chk_ok;
    logic                 w_commit_ok;

    c499_key_chk #(
        .KEY_W (KEY_W),
        .CHK_W (CHK_W)
    ) u_chk (
        .i_key (r_sr[KEY_W-1:0]),
        .o_chk (w_chk_calc)
    );

    assign w_full      = (r_cnt == c_CNT_FULL);
    assign w_chk_ok    = (w_chk_calc == r_sr[c_FRAME_W-1:KEY_W]);
    assign w_commit_ok = w_full && w_chk_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_cnt   <= '0;
            r_key   <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
            r_err   <= w_err_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    // Frame enters LSB first and shifts right, so after FRAME_W bits bit 0 sits at r_sr[0]
    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_cnt_nxt   = r_cnt;
        if (key_clear) begin
            w_state_nxt = ST_IDLE;
            w_sr_nxt    = '0;
            w_cnt_nxt   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (key_sen) begin
                        w_state_nxt = ST_SHIFT;
                        w_sr_nxt    = {key_sdi, r_sr[c_FRAME_W-1:1]};
                        w_cnt_nxt   = c_CNT_ONE;
                    end
                end
                ST_SHIFT: begin
                    if (key_commit) begin
                        w_state_nxt = w_commit_ok ? ST_LOCKED : ST_ERROR;
                    end else if (key_sen) begin
                        if (w_full) begin
                            w_state_nxt = ST_ERROR;
                        end else begin
                            w_sr_nxt  = {key_sdi, r_sr[c_FRAME_W-1:1]};
                            w_cnt_nxt = r_cnt + c_CNT_ONE;
                        end
                    end
                end
                default: begin
                    w_state_nxt = r_state;
                end
            endcase
        end
    end

    // The key register only ever holds a nonzero value while LOCKED
    always_comb begin
        w_valid_nxt = (w_state_nxt == ST_LOCKED);
        w_err_nxt   = (w_state_nxt == ST_ERROR);
        w_busy_nxt  = (w_state_nxt == ST_SHIFT);
        w_key_nxt   = '0;
        if (w_state_nxt == ST_LOCKED) begin
            w_key_nxt = (r_state == ST_LOCKED) ? r_key : r_sr[KEY_W-1:0];
        end
    end

    assign key       = r_key;
    assign key_valid = r_valid;
    assign key_err   = r_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_c499_key_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_c499_key_loader
// Brief   : Scoreboard bench for the c499 key loader (default 32+8 frame).
// Rev     : 1.0 - initial release
// ============================================================================
module tb_c499_key_loader;

    localparam int c_ST_IDLE   = 0;
    localparam int c_ST_SHIFT  = 1;
    localparam int c_ST_LOCKED = 2;
    localparam int c_ST_ERROR  = 3;

    typedef struct {
        string       tag;
        logic [31:0] key;
        logic        valid;
        logic        err;
        logic        busy;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        key_sdi;
    logic        key_sen;
    logic        key_commit;
    logic        key_clear;
    logic [31:0] key;
    logic        key_valid;
    logic        key_err;
    logic        busy;

    int          n_total;
    int          n_bad;
    exp_t        sb_q[$];

    int          m_st;
    int          m_cnt;
    logic [39:0] m_frame;
    logic [31:0] m_key;

    c499_key_loader #(
        .KEY_W (32),
        .CHK_W (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_sdi    (key_sdi),
        .key_sen    (key_sen),
        .key_commit (key_commit),
        .key_clear  (key_clear),
        .key        (key),
        .key_valid  (key_valid),
        .key_err    (key_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] csum(input logic [31:0] k);
        return k[7:0] ^ k[15:8] ^ k[23:16] ^ k[31:24];
    endfunction

    task automatic model_reset();
        m_st    = c_ST_IDLE;
        m_cnt   = 0;
        m_frame = '0;
        m_key   = '0;
    endtask

    task automatic model_step(input logic sen, input logic sdi, input logic commit, input logic clr);
        if (clr) begin
            model_reset();
        end else begin
            case (m_st)
                c_ST_IDLE: if (sen) begin
                    m_frame    = '0;
                    m_frame[0] = sdi;
                    m_cnt      = 1;
                    m_st       = c_ST_SHIFT;
                end
                c_ST_SHIFT: begin
                    if (commit) begin
                        if (m_cnt == 40 && csum(m_frame[31:0]) == m_frame[39:32]) begin
                            m_st  = c_ST_LOCKED;
                            m_key = m_frame[31:0];
                        end else begin
                            m_st = c_ST_ERROR;
                        end
                    end else if (sen) begin
                        if (m_cnt == 40) begin
                            m_st = c_ST_ERROR;
                        end else begin
                            m_frame[m_cnt] = sdi;
                            m_cnt++;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("sb_empty", 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            check({e.tag, ".key"},   64'(key),       64'(e.key));
            check({e.tag, ".valid"}, 64'(key_valid), 64'(e.valid));
            check({e.tag, ".err"},   64'(key_err),   64'(e.err));
            check({e.tag, ".busy"},  64'(busy),      64'(e.busy));
        end
    endtask

    // Drive one cycle, push the model's post-edge expectation, then compare after the edge
    task automatic step(input string tag, input logic sen, input logic sdi,
                        input logic commit, input logic clr);
        exp_t e;
        key_sen    = sen;
        key_sdi    = sdi;
        key_commit = commit;
        key_clear  = clr;
        model_step(sen, sdi, commit, clr);
        e.tag   = tag;
        e.valid = (m_st == c_ST_LOCKED);
        e.err   = (m_st == c_ST_ERROR);
        e.busy  = (m_st == c_ST_SHIFT);
        e.key   = (m_st == c_ST_LOCKED) ? m_key : 32'h0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        key_sen    = 1'b0;
        key_sdi    = 1'b0;
        key_commit = 1'b0;
        key_clear  = 1'b0;
        compare_out();
    endtask

    task automatic send_bits(input string tag, input logic [63:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            step(tag, 1'b1, f[i], 1'b0, 1'b0);
        end
    endtask

    task automatic check_outs(input string tag, input logic [31:0] k, input logic v,
                              input logic er, input logic b);
        check({tag, ".key"},   64'(key),       64'(k));
        check({tag, ".valid"}, 64'(key_valid), 64'(v));
        check({tag, ".err"},   64'(key_err),   64'(er));
        check({tag, ".busy"},  64'(busy),      64'(b));
    endtask

    initial begin
        logic [63:0] f_good;
        logic [63:0] f_bad;
        logic [31:0] rk;
        n_total    = 0;
        n_bad      = 0;
        rst        = 1'b1;
        key_sdi    = 1'b0;
        key_sen    = 1'b0;
        key_commit = 1'b0;
        key_clear  = 1'b0;
        model_reset();
        f_good = {24'h0, 8'h08, 32'h12345678};
        f_bad  = {24'h0, 8'h09, 32'h12345678};

        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Good frame locks one cycle after commit; commit in LOCKED is ignored
        send_bits("good", f_good, 40);
        step("good_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("good_lock", 32'h12345678, 1'b1, 1'b0, 1'b0);
        step("locked_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        step("clr1", 1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("clr1_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Bad checksum
        send_bits("badck", f_bad, 40);
        step("badck_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("badck_err", 32'h0, 1'b0, 1'b1, 1'b0);
        step("err_sen", 1'b1, 1'b1, 1'b0, 1'b0);
        step("clr2", 1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("clr2_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Short frame
        send_bits("short", f_good, 39);
        step("short_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("short_err", 32'h0, 1'b0, 1'b1, 1'b0);
        step("clr3", 1'b0, 1'b0, 1'b0, 1'b1);

        // Overflow on the 41st bit
        send_bits("ovf", f_good, 40);
        check_outs("ovf_40", 32'h0, 1'b0, 1'b0, 1'b1);
        step("ovf_41", 1'b1, 1'b0, 1'b0, 1'b0);
        check_outs("ovf_err", 32'h0, 1'b0, 1'b1, 1'b0);
        step("clr4", 1'b0, 1'b0, 1'b0, 1'b1);

        // Lock, then further shifts and a commit must not disturb the key
        send_bits("relock", f_good, 40);
        step("relock_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        send_bits("locked_shift", ~f_good, 40);
        step("locked_commit2", 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("locked_stable", 32'h12345678, 1'b1, 1'b0, 1'b0);

        // Clear wins over commit and shift
        step("clr_all", 1'b1, 1'b1, 1'b1, 1'b1);
        check_outs("clr_all_idle", 32'h0, 1'b0, 1'b0, 1'b0);

        // Shift coincident with a commit on a full frame is discarded and the frame locks
        send_bits("cosen", f_good, 40);
        step("cosen_commit", 1'b1, 1'b1, 1'b1, 1'b0);
        check_outs("cosen_lock", 32'h12345678, 1'b1, 1'b0, 1'b0);
        step("clr5", 1'b0, 1'b0, 1'b0, 1'b1);

        // Asynchronous reset mid-frame
        send_bits("partial", f_good, 20);
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 32'h0, 1'b0, 1'b0, 1'b0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        send_bits("fresh", f_good, 40);
        step("fresh_commit", 1'b0, 1'b0, 1'b1, 1'b0);
        check_outs("fresh_lock", 32'h12345678, 1'b1, 1'b0, 1'b0);
        step("clr6", 1'b0, 1'b0, 1'b0, 1'b1);

        // A few random well-formed frames
        for (int k = 0; k < 4; k++) begin
            rk = $urandom;
            send_bits("rnd", {24'h0, csum(rk), rk}, 40);
            step("rnd_commit", 1'b0, 1'b0, 1'b1, 1'b0);
            check("rnd_key", 64'(key), 64'(rk));
            step("rnd_clr", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
